// File: rtl/qk_dot_product_tiled_if.sv
// Handshake bundle between the Q/K vector buffers, the tiled dot-product
// stage and the downstream score consumer.
interface qk_dot_product_tiled_if #(
    parameter int LANES   = 16,
    parameter int ELEM_W  = 8,
    parameter int SCORE_W = 8
);
    logic                      q_vld_in;
    logic                      k_vld_in;
    logic                      q_rdy_out;
    logic                      k_rdy_out;
    logic [LANES*ELEM_W-1:0]   q_in;
    logic [LANES*ELEM_W-1:0]   k_in;
    logic                      vld_out;
    logic                      rdy_in;
    logic [SCORE_W-1:0]        s_out;
    logic                      sat_out;

    modport slave (
        input  q_vld_in, k_vld_in, q_in, k_in, rdy_in,
        output q_rdy_out, k_rdy_out, vld_out, s_out, sat_out
    );

    modport master (
        output q_vld_in, k_vld_in, q_in, k_in, rdy_in,
        input  q_rdy_out, k_rdy_out, vld_out, s_out, sat_out
    );
endinterface

// File: rtl/qk_dot_product_tiled.sv
// Multi-beat Q.K dot product: accumulates LANES products per beat over DIM/LANES
// beats, scales by a right shift, optionally rounds, saturates and emits a score.
module qk_dot_product_tiled #(
    parameter int DIM     = 64,
    parameter int LANES   = 16,
    parameter int ELEM_W  = 8,
    parameter int SCORE_W = 8,
    parameter int SHIFT   = 3,
    parameter int ROUND   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    qk_dot_product_tiled_if.slave     bus
);
    localparam int NBEATS = DIM / LANES;
    localparam int ACC_W  = 2 * ELEM_W + $clog2(DIM);
    localparam int T_W    = ACC_W + 1;
    localparam int S      = 2 * (ELEM_W - 1) - (SCORE_W - 1) + SHIFT;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_OUT   = 1'b1;

    localparam logic signed [T_W-1:0] MAX_C = T_W'((2 ** (SCORE_W - 1)) - 1);
    localparam logic signed [T_W-1:0] MIN_C = T_W'(-(2 ** (SCORE_W - 1)));
    localparam logic signed [T_W-1:0] RND_C =
        (ROUND != 0 && S > 0) ? (T_W'(1) << ((S > 0) ? S - 1 : 0)) : T_W'(0);

    if (DIM % LANES != 0) begin : g_dim_chk
        $fatal(1, "DIM must be a multiple of LANES");
    end
    if (LANES < 1 || (LANES & (LANES - 1)) != 0) begin : g_lanes_chk
        $fatal(1, "LANES must be a power of two");
    end

    // Pairwise reduction of the lane products; each level halves the operand count.
    function automatic logic signed [ACC_W-1:0] beat_sum(
        input logic [LANES*ELEM_W-1:0] q,
        input logic [LANES*ELEM_W-1:0] k
    );
        logic signed [ACC_W-1:0]    v [LANES];
        logic signed [ELEM_W-1:0]   qs;
        logic signed [ELEM_W-1:0]   ks;
        logic signed [2*ELEM_W-1:0] p;
        for (int i = 0; i < LANES; i++) begin
            qs   = q[i*ELEM_W +: ELEM_W];
            ks   = k[i*ELEM_W +: ELEM_W];
            p    = (2*ELEM_W)'(qs) * (2*ELEM_W)'(ks);
            v[i] = ACC_W'(p);
        end
        for (int w = LANES / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                v[i] = v[2*i] + v[2*i+1];
            end
        end
        return v[0];
    endfunction

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    vld_q, vld_d;
    logic [SCORE_W-1:0]      s_q, s_d;
    logic                    sat_q, sat_d;

    logic                    fire_s;
    logic                    last_s;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [T_W-1:0]   t_s;
    logic signed [T_W-1:0]   r_s;
    logic [SCORE_W-1:0]      clip_s;
    logic                    sat_s;

    assign bus.q_rdy_out = (state_q == ST_ACCUM) && bus.k_vld_in;
    assign bus.k_rdy_out = (state_q == ST_ACCUM) && bus.q_vld_in;
    assign bus.vld_out   = vld_q;
    assign bus.s_out     = s_q;
    assign bus.sat_out   = sat_q;

    // Datapath: accumulate this beat, scale, round and clip the candidate score.
    always_comb begin
        fire_s     = (state_q == ST_ACCUM) && bus.q_vld_in && bus.k_vld_in;
        last_s     = (cnt_q == CNT_W'(NBEATS - 1));
        acc_next_s = acc_q + beat_sum(bus.q_in, bus.k_in);
        t_s        = T_W'(acc_next_s) + RND_C;
        r_s        = t_s >>> S;
        if (r_s > MAX_C) begin
            clip_s = MAX_C[SCORE_W-1:0];
            sat_s  = 1'b1;
        end else if (r_s < MIN_C) begin
            clip_s = MIN_C[SCORE_W-1:0];
            sat_s  = 1'b1;
        end else begin
            clip_s = r_s[SCORE_W-1:0];
            sat_s  = 1'b0;
        end
    end

    // Next-state logic for the accumulate / hold-result controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        vld_d   = vld_q;
        s_d     = s_q;
        sat_d   = sat_q;
        case (state_q)
            ST_ACCUM: begin
                if (fire_s && last_s) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    vld_d   = 1'b1;
                    s_d     = clip_s;
                    sat_d   = sat_s;
                    state_d = ST_OUT;
                end else if (fire_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = acc_next_s;
                end else begin
                    cnt_d = cnt_q;
                    acc_d = acc_q;
                end
            end
            ST_OUT: begin
                if (bus.rdy_in) begin
                    vld_d   = 1'b0;
                    state_d = ST_ACCUM;
                end else begin
                    vld_d   = 1'b1;
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_ACCUM;
                vld_d   = 1'b0;
            end
        endcase
    end

    // Controller and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            vld_q   <= 1'b0;
            s_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            vld_q   <= vld_d;
            s_q     <= s_d;
            sat_q   <= sat_d;
        end
    end
endmodule
